mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters: instruction fetch (IF) and the MEM-stage data access driven by the decoded MemRead/MemWrite controls.
- At most one memory transaction is outstanding. Data accesses have priority, with an anti-starvation limit for fetch. A timeout aborts hung transactions.
- Per-requester stall outputs feed the pipeline hazard/stall logic.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_timer.sv | 30 +++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_MAX_DSTREAK = 4;
    localparam int unsigned DEF_TIMEOUT     = 64;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter: cleared at grant, advanced while waiting, flags TIMEOUT-1.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and MEM-stage data,
// one transaction at a time, data-first with a fetch anti-starvation limit and a timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned MAX_DSTREAK = DEF_MAX_DSTREAK,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    input  logic                d_rd,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                stall_if,
    output logic                stall_d,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err_timeout
);

    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned STREAK_W = cnt_width(MAX_DSTREAK + 1);

    arb_state_t          state, state_d;
    owner_t              owner, owner_d;
    logic [STREAK_W-1:0] dstreak, dstreak_d;

    logic                mem_req_d, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic [BE_W-1:0]     mem_be_d;
    logic [DATA_W-1:0]   if_rdata_d, d_rdata_d;
    logic                if_done_d, d_done_d, err_timeout_d;

    logic                timer_clear, timer_enable, timer_expired;
    logic                d_pend, streak_full, grant_data;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (timer_clear),
        .enable    (timer_enable),
        .expired_c (timer_expired)
    );

    assign stall_if = if_req & ~if_done;
    assign stall_d  = (d_rd | d_wr) & ~d_done;

    // Data wins unless fetch has already watched MAX_DSTREAK data grants go by.
    assign d_pend      = d_rd | d_wr;
    assign streak_full = (dstreak == STREAK_W'(MAX_DSTREAK));
    assign grant_data  = d_pend & ~(if_req & streak_full);

    always_comb begin
        state_d       = state;
        owner_d       = owner;
        dstreak_d     = dstreak;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_be_d      = mem_be;
        if_rdata_d    = if_rdata;
        d_rdata_d     = d_rdata;
        if_done_d     = 1'b0;
        d_done_d      = 1'b0;
        err_timeout_d = 1'b0;
        timer_clear   = 1'b0;
        timer_enable  = 1'b0;

        case (state)
            IDLE: begin
                if (grant_data) begin
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    timer_clear = 1'b1;
                    state_d     = BUSY;
                    if (if_req && !streak_full) begin
                        dstreak_d = dstreak + STREAK_W'(1);
                    end
                end else if (if_req) begin
                    owner_d     = OWN_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    timer_clear = 1'b1;
                    dstreak_d   = '0;
                    state_d     = BUSY;
                end
            end

            BUSY: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (owner == OWN_D) begin
                        d_rdata_d = mem_we ? '0 : mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end else if (timer_expired) begin
                    mem_req_d     = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = RESP;
                    if (owner == OWN_D) begin
                        d_rdata_d = '0;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    timer_enable = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_I;
            dstreak     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            dstreak     <= dstreak_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_be      <= mem_be_d;
            if_rdata    <= if_rdata_d;
            d_rdata     <= d_rdata_d;
            if_done     <= if_done_d;
            d_done      <= d_done_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a grant/done scoreboard and a small memory responder.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_rd, d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          stall_if, stall_d;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          err_timeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_DSTREAK (4),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .d_rd        (d_rd),
        .d_wr        (d_wr),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_be        (d_be),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .stall_if    (stall_if),
        .stall_d     (stall_d),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } grant_t;

    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] rdata;
        logic          err;
    } done_t;

    grant_t grant_q[$];
    done_t  done_q[$];
    grant_t cur;
    done_t  dexp;
    logic   req_prev = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a == 32'h0000_0100) ? 32'h0050_0093 : ~a;
    endfunction

    task automatic exp_grant(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [BW-1:0] be);
        grant_t g;
        g.we = we; g.addr = a; g.wdata = wd; g.be = be;
        grant_q.push_back(g);
    endtask

    task automatic exp_done(input logic is_d, input logic [DW-1:0] rd, input logic err);
        done_t d;
        d.is_d = is_d; d.rdata = rd; d.err = err;
        done_q.push_back(d);
    endtask

    // Memory responder: ready after wait_cycles cycles of mem_req, or never when hang is set.
    int wait_cycles = 0;
    bit hang = 1'b0;
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (mem_req !== 1'b1) begin
            busy_cnt  = 0;
            mem_ready = 1'b0;
            mem_rdata = '0;
        end else begin
            if (!hang && busy_cnt == wait_cycles) begin
                mem_ready = 1'b1;
                mem_rdata = mem_model(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = '0;
            end
            busy_cnt++;
        end
    end

    // Scoreboard monitor: grants checked on mem_req rise and held while high; dones popped in order.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && req_prev !== 1'b1) begin
            chk("grant_expected", 32'(grant_q.size() != 0), 32'd1);
            if (grant_q.size() != 0) begin
                cur = grant_q.pop_front();
                chk("grant_we", 32'(mem_we), 32'(cur.we));
                chk("grant_addr", mem_addr, cur.addr);
                chk("grant_be", 32'(mem_be), 32'(cur.be));
                if (cur.we) chk("grant_wdata", mem_wdata, cur.wdata);
            end
        end else if (mem_req === 1'b1) begin
            chk("hold_we", 32'(mem_we), 32'(cur.we));
            chk("hold_addr", mem_addr, cur.addr);
            chk("hold_be", 32'(mem_be), 32'(cur.be));
        end
        if (if_done === 1'b1 || d_done === 1'b1) begin
            chk("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                dexp = done_q.pop_front();
                chk("done_owner", 32'({if_done, d_done}), dexp.is_d ? 32'd1 : 32'd2);
                chk("done_rdata", dexp.is_d ? d_rdata : if_rdata, dexp.rdata);
                chk("done_err", 32'(err_timeout), 32'(dexp.err));
            end
        end else begin
            chk("err_quiet", 32'(err_timeout), 32'd0);
        end
        req_prev = mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the drive cycle (cycle 0) until a done pulse.
    task automatic measure(input int bound, output int done_cyc, output int req_cyc);
        done_cyc = -1;
        req_cyc  = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) req_cyc++;
            if (if_done === 1'b1 || d_done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        chk("measure_bound", 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic wait_done(input int bound, output logic got_i, output logic got_d);
        got_i = 1'b0;
        got_d = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (if_done === 1'b1 || d_done === 1'b1) begin
                got_i = if_done;
                got_d = d_done;
                break;
            end
        end
        chk("wait_done_bound", 32'(got_i | got_d), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dc, rc;
        logic gi, gd;

        reset = 1'b0; if_req = 1'b0; if_addr = '0;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Fetch only, zero-wait memory
        exp_grant(1'b0, 32'h100, 32'h0, 4'hF);
        exp_done(1'b0, 32'h0050_0093, 1'b0);
        if_req = 1'b1; if_addr = 32'h100;
        measure(20, dc, rc);
        chk("fetch_done_cycle", 32'(dc), 32'd2);
        chk("fetch_req_cycles", 32'(rc), 32'd1);
        chk("fetch_stall_if_at_done", 32'(stall_if), 32'd0);
        tick();
        if_req = 1'b0;
        tick();

        // Simultaneous requests: data first, then fetch
        exp_grant(1'b0, 32'h2000, 32'h0, 4'hF);
        exp_done(1'b1, ~32'h2000, 1'b0);
        exp_grant(1'b0, 32'h200, 32'h0, 4'hF);
        exp_done(1'b0, ~32'h200, 1'b0);
        if_req = 1'b1; if_addr = 32'h200;
        d_rd = 1'b1; d_addr = 32'h2000; d_be = 4'hF;
        @(negedge clk);
        chk("both_stall_if_c0", 32'(stall_if), 32'd1);
        chk("both_stall_d_c0", 32'(stall_d), 32'd1);
        wait_done(40, gi, gd);
        chk("both_first_is_data", 32'(gd), 32'd1);
        tick();
        d_rd = 1'b0;
        wait_done(40, gi, gd);
        chk("both_second_is_fetch", 32'(gi), 32'd1);
        tick();
        if_req = 1'b0;
        tick();

        // Anti-starvation: two rounds of 4 data grants then a fetch, then a lone data access
        begin
            logic [AW-1:0] da;
            da = 32'h3000;
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < 4; k++) begin
                    exp_grant(1'b0, da, 32'h0, 4'hF);
                    exp_done(1'b1, ~da, 1'b0);
                    da = da + 32'd4;
                end
                exp_grant(1'b0, 32'h300 + 32'(4 * r), 32'h0, 4'hF);
                exp_done(1'b0, ~(32'h300 + 32'(4 * r)), 1'b0);
            end
            exp_grant(1'b0, da, 32'h0, 4'hF);
            exp_done(1'b1, ~da, 1'b0);
        end
        if_req = 1'b1; if_addr = 32'h300;
        d_rd = 1'b1; d_addr = 32'h3000; d_be = 4'hF;
        for (int n = 0; n < 11; n++) begin
            wait_done(40, gi, gd);
            tick();
            if (gi) begin
                if (if_addr == 32'h300) if_addr = 32'h304;
                else if_req = 1'b0;
            end
            if (gd) begin
                if (d_addr == 32'h3020) d_rd = 1'b0;
                else d_addr = d_addr + 32'd4;
            end
        end
        tick();

        // Store with three wait cycles
        wait_cycles = 3;
        exp_grant(1'b1, 32'h40, 32'hDEAD_BEEF, 4'h3);
        exp_done(1'b1, 32'h0, 1'b0);
        d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
        measure(20, dc, rc);
        chk("store_done_cycle", 32'(dc), 32'd5);
        chk("store_req_cycles", 32'(rc), 32'd4);
        chk("store_stall_d_at_done", 32'(stall_d), 32'd0);
        tick();
        d_wr = 1'b0; wait_cycles = 0;
        tick();

        // Timeout abort
        hang = 1'b1;
        exp_grant(1'b0, 32'h80, 32'h0, 4'hF);
        exp_done(1'b1, 32'h0, 1'b1);
        d_rd = 1'b1; d_addr = 32'h80; d_be = 4'hF;
        measure(40, dc, rc);
        chk("timeout_req_cycles", 32'(rc), 32'(TO));
        chk("timeout_done_cycle", 32'(dc), 32'(TO + 1));
        tick();
        d_rd = 1'b0; hang = 1'b0;
        tick();

        // Read and write together behave as a write
        exp_grant(1'b1, 32'h44, 32'h1234_5678, 4'hF);
        exp_done(1'b1, 32'h0, 1'b0);
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678; d_be = 4'hF;
        measure(20, dc, rc);
        chk("rdwr_done_cycle", 32'(dc), 32'd2);
        tick();
        d_rd = 1'b0; d_wr = 1'b0;
        tick();

        // Reset while BUSY abandons the transaction silently
        hang = 1'b1;
        exp_grant(1'b0, 32'h500, 32'h0, 4'hF);
        d_rd = 1'b1; d_addr = 32'h500; d_be = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_busy_req_high", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; d_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy_req_low", 32'(mem_req), 32'd0);
        chk("rst_busy_no_done", 32'(d_done), 32'd0);
        repeat (4) @(negedge clk);
        hang = 1'b0;
        tick();
        exp_grant(1'b0, 32'h100, 32'h0, 4'hF);
        exp_done(1'b0, 32'h0050_0093, 1'b0);
        if_req = 1'b1; if_addr = 32'h100;
        measure(20, dc, rc);
        chk("post_rst_fetch_cycle", 32'(dc), 32'd2);
        tick();
        if_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
